// File: rtl/des_key_schedule.sv
// DES key schedule: emits the sixteen 48-bit round subkeys, K1..K16 or K16..K1.
// Latency: key accept -> first subkey valid next cycle; one subkey per accepted cycle.
// Backpressure: subkey/round_cnt held while subkey_ready=0; key_ready low for the whole schedule.
module des_key_schedule (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [63:0] key_in,
   input  logic        key_valid,
   output logic        key_ready,
   input  logic        decrypt,
   output logic [47:0] subkey,
   output logic        subkey_valid,
   input  logic        subkey_ready,
   output logic [3:0]  round_cnt,
   output logic        done
);

   typedef enum logic {ST_IDLE, ST_GEN} state_t;

   // FIPS bit positions (1 = MSB), first table entry is the output MSB
   localparam logic [56*6-1:0] PC1_TAB = {
      6'd57, 6'd49, 6'd41, 6'd33, 6'd25, 6'd17, 6'd9,
      6'd1,  6'd58, 6'd50, 6'd42, 6'd34, 6'd26, 6'd18,
      6'd10, 6'd2,  6'd59, 6'd51, 6'd43, 6'd35, 6'd27,
      6'd19, 6'd11, 6'd3,  6'd60, 6'd52, 6'd44, 6'd36,
      6'd63, 6'd55, 6'd47, 6'd39, 6'd31, 6'd23, 6'd15,
      6'd7,  6'd62, 6'd54, 6'd46, 6'd38, 6'd30, 6'd22,
      6'd14, 6'd6,  6'd61, 6'd53, 6'd45, 6'd37, 6'd29,
      6'd21, 6'd13, 6'd5,  6'd28, 6'd20, 6'd12, 6'd4};

   localparam logic [48*6-1:0] PC2_TAB = {
      6'd14, 6'd17, 6'd11, 6'd24, 6'd1,  6'd5,
      6'd3,  6'd28, 6'd15, 6'd6,  6'd21, 6'd10,
      6'd23, 6'd19, 6'd12, 6'd4,  6'd26, 6'd8,
      6'd16, 6'd7,  6'd27, 6'd20, 6'd13, 6'd2,
      6'd41, 6'd52, 6'd31, 6'd37, 6'd47, 6'd55,
      6'd30, 6'd40, 6'd51, 6'd45, 6'd33, 6'd48,
      6'd44, 6'd49, 6'd39, 6'd56, 6'd34, 6'd53,
      6'd46, 6'd42, 6'd50, 6'd36, 6'd29, 6'd32};

   function automatic logic [55:0] pc1(input logic [63:0] k);
      logic [55:0] r;
      logic [5:0]  tab;
      logic [5:0]  src;
      r = '0;
      for (int i = 0; i < 56; i++) begin
         tab   = PC1_TAB[i*6 +: 6];
         src   = 6'(7'd64 - {1'b0, tab});
         r[i]  = k[src];
      end
      return r;
   endfunction

   function automatic logic [47:0] pc2(input logic [55:0] cd);
      logic [47:0] r;
      logic [5:0]  tab;
      logic [5:0]  src;
      r = '0;
      for (int i = 0; i < 48; i++) begin
         tab   = PC2_TAB[i*6 +: 6];
         src   = 6'd56 - tab;
         r[i]  = cd[src];
      end
      return r;
   endfunction

   // Per-round left-shift amounts; rounds 1, 2, 9 and 16 shift by one
   function automatic logic shift_one(input logic [3:0] idx);
      return (idx == 4'd0) || (idx == 4'd1) || (idx == 4'd8) || (idx == 4'd15);
   endfunction

   function automatic logic [27:0] rotl28(input logic [27:0] x, input logic one);
      return one ? {x[26:0], x[27]} : {x[25:0], x[27:26]};
   endfunction

   function automatic logic [27:0] rotr28(input logic [27:0] x, input logic one);
      return one ? {x[0], x[27:1]} : {x[1:0], x[27:2]};
   endfunction

   state_t      state_q, state_d;
   logic [27:0] c_q, c_d, d_q, d_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        dec_q, dec_d;
   logic        done_q, done_d;
   logic        key_ready_q, subkey_valid_q;
   logic [55:0] cd0;

   assign cd0 = pc1(key_in);

   // Next-state: load C0/D0 on key accept, then rotate one round per accepted subkey
   always_comb begin
      state_d = state_q;
      c_d     = c_q;
      d_d     = d_q;
      cnt_d   = cnt_q;
      dec_d   = dec_q;
      done_d  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (key_valid) begin
               dec_d   = decrypt;
               cnt_d   = 4'd0;
               state_d = ST_GEN;
               // Decrypt starts at K16, whose cumulative shift of 28 is the identity
               if (decrypt) begin
                  c_d = cd0[55:28];
                  d_d = cd0[27:0];
               end else begin
                  c_d = rotl28(cd0[55:28], 1'b1);
                  d_d = rotl28(cd0[27:0], 1'b1);
               end
            end
         end
         default: begin
            if (subkey_ready) begin
               if (cnt_q == 4'd15) begin
                  state_d = ST_IDLE;
                  cnt_d   = 4'd0;
                  done_d  = 1'b1;
               end else begin
                  cnt_d = cnt_q + 4'd1;
                  if (dec_q) begin
                     c_d = rotr28(c_q, shift_one(4'd15 - cnt_q));
                     d_d = rotr28(d_q, shift_one(4'd15 - cnt_q));
                  end else begin
                     c_d = rotl28(c_q, shift_one(cnt_q + 4'd1));
                     d_d = rotl28(d_q, shift_one(cnt_q + 4'd1));
                  end
               end
            end
         end
      endcase
   end

   // State, key registers and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q        <= ST_IDLE;
         c_q            <= '0;
         d_q            <= '0;
         cnt_q          <= '0;
         dec_q          <= 1'b0;
         done_q         <= 1'b0;
         key_ready_q    <= 1'b1;
         subkey_valid_q <= 1'b0;
      end else begin
         state_q        <= state_d;
         c_q            <= c_d;
         d_q            <= d_d;
         cnt_q          <= cnt_d;
         dec_q          <= dec_d;
         done_q         <= done_d;
         key_ready_q    <= (state_d == ST_IDLE);
         subkey_valid_q <= (state_d == ST_GEN);
      end
   end

   assign subkey       = pc2({c_q, d_q});
   assign key_ready    = key_ready_q;
   assign subkey_valid = subkey_valid_q;
   assign round_cnt    = cnt_q;
   assign done         = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Bench for des_key_schedule: random stalls/keys against a table-driven subkey model.
// Model derives each subkey from cumulative shift counts on bit arrays.
// Inputs driven and outputs sampled on the falling clock edge.
module tb_des_key_schedule;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [63:0] key_in = '0;
   logic        key_valid = 1'b0;
   logic        key_ready;
   logic        decrypt = 1'b0;
   logic [47:0] subkey;
   logic        subkey_valid;
   logic        subkey_ready = 1'b0;
   logic [3:0]  round_cnt;
   logic        done;

   des_key_schedule dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .key_in       (key_in),
      .key_valid    (key_valid),
      .key_ready    (key_ready),
      .decrypt      (decrypt),
      .subkey       (subkey),
      .subkey_valid (subkey_valid),
      .subkey_ready (subkey_ready),
      .round_cnt    (round_cnt),
      .done         (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   int PC1[56] = '{57,49,41,33,25,17,9, 1,58,50,42,34,26,18, 10,2,59,51,43,35,27,
                   19,11,3,60,52,44,36, 63,55,47,39,31,23,15, 7,62,54,46,38,30,22,
                   14,6,61,53,45,37,29, 21,13,5,28,20,12,4};
   int PC2[48] = '{14,17,11,24,1,5, 3,28,15,6,21,10, 23,19,12,4,26,8, 16,7,27,20,13,2,
                   41,52,31,37,47,55, 30,40,51,45,33,48, 44,49,39,56,34,53, 46,42,50,36,29,32};
   int SH[16]  = '{1,1,2,2,2,2,2,2,1,2,2,2,2,2,2,1};

   localparam logic [63:0] TKEY = 64'h133457799BBCDFF1;
   localparam logic [47:0] K1   = 48'h1B02EFFC7072;
   localparam logic [47:0] K16  = 48'hCB3D8B0E17F5;

   logic [47:0] exp_enc[16];
   logic [47:0] obs[16];
   int          last_cycles;

   // Encrypt-order subkeys from cumulative rotation counts
   task automatic model(input logic [63:0] key);
      logic kb[1:64];
      logic cd[1:56];
      int   s, p, src;
      for (int n = 1; n <= 64; n++) kb[n] = key[64-n];
      for (int i = 1; i <= 56; i++) cd[i] = kb[PC1[i-1]];
      s = 0;
      for (int r = 0; r < 16; r++) begin
         s += SH[r];
         for (int j = 1; j <= 48; j++) begin
            p = PC2[j-1];
            if (p <= 28) src = ((p - 1 + s) % 28) + 1;
            else         src = 28 + ((p - 29 + s) % 28) + 1;
            exp_enc[r][48-j] = cd[src];
         end
      end
   endtask

   // Load one key and consume its full schedule, checking every cycle
   task automatic run_sched(input logic [63:0] key, input logic dec, input int stall_pct,
                            input bit glitch);
      int          idx, cyc;
      logic [47:0] expk;
      model(key);
      @(negedge clk);
      checks++;
      if (key_ready !== 1'b1) begin
         errors++; $display("FAIL load_key_ready got %b want 1", key_ready);
      end
      key_in = key; decrypt = dec; key_valid = 1'b1; subkey_ready = 1'b0;
      @(negedge clk);
      key_valid = 1'b0; key_in = {$urandom, $urandom}; decrypt = ~dec;
      idx = 0; cyc = 0;
      while (idx < 16 && cyc < 600) begin
         cyc++;
         expk = dec ? exp_enc[15-idx] : exp_enc[idx];
         checks++;
         if (subkey_valid !== 1'b1) begin
            errors++; $display("FAIL gen_valid idx %0d got %b want 1", idx, subkey_valid);
         end
         checks++;
         if (round_cnt !== 4'(idx)) begin
            errors++; $display("FAIL round_cnt got %0d want %0d", round_cnt, idx);
         end
         checks++;
         if (subkey !== expk) begin
            errors++; $display("FAIL subkey idx %0d dec %b got %h want %h", idx, dec, subkey, expk);
         end
         checks++;
         if (key_ready !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL gen_flags idx %0d key_ready %b done %b want 0 0", idx, key_ready, done);
         end
         obs[idx] = subkey;
         subkey_ready = ($urandom_range(99) >= stall_pct);
         if (glitch) begin
            key_valid = 1'($urandom_range(1));
            key_in    = {$urandom, $urandom};
         end
         @(negedge clk);
         if (subkey_ready) idx++;
      end
      key_valid = 1'b0; subkey_ready = 1'b0;
      last_cycles = cyc;
      checks++;
      if (idx != 16) begin
         errors++; $display("FAIL sched_timeout accepts %0d want 16", idx);
      end
      checks++;
      if (done !== 1'b1 || subkey_valid !== 1'b0 || key_ready !== 1'b1 || round_cnt !== 4'd0) begin
         errors++;
         $display("FAIL end_state done %b valid %b ready %b cnt %0d want 1 0 1 0",
                  done, subkey_valid, key_ready, round_cnt);
      end
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin
         errors++; $display("FAIL done_pulse_width got %b want 0", done);
      end
   endtask

   task automatic test_reset();
      checks++;
      if (key_ready !== 1'b1 || subkey_valid !== 1'b0 || round_cnt !== 4'd0 ||
          done !== 1'b0 || subkey !== 48'h0) begin
         errors++;
         $display("FAIL reset_state ready %b valid %b cnt %0d done %b subkey %h want 1 0 0 0 0",
                  key_ready, subkey_valid, round_cnt, done, subkey);
      end
   endtask

   task automatic test_encrypt();
      run_sched(TKEY, 1'b0, 0, 1'b0);
      checks++;
      if (obs[0] !== K1) begin errors++; $display("FAIL enc_k1 got %h want %h", obs[0], K1); end
      checks++;
      if (obs[15] !== K16) begin errors++; $display("FAIL enc_k16 got %h want %h", obs[15], K16); end
      checks++;
      if (last_cycles != 16) begin
         errors++; $display("FAIL enc_throughput got %0d cycles want 16", last_cycles);
      end
   endtask

   task automatic test_decrypt();
      run_sched(TKEY, 1'b1, 0, 1'b0);
      checks++;
      if (obs[0] !== K16) begin errors++; $display("FAIL dec_first got %h want %h", obs[0], K16); end
      checks++;
      if (obs[15] !== K1) begin errors++; $display("FAIL dec_last got %h want %h", obs[15], K1); end
   endtask

   task automatic test_stall();
      run_sched(TKEY, 1'b0, 40, 1'b0);
      checks++;
      if (obs[0] !== K1 || obs[15] !== K16) begin
         errors++; $display("FAIL stall_ends got %h %h want %h %h", obs[0], obs[15], K1, K16);
      end
   endtask

   task automatic test_key_glitch();
      run_sched(TKEY, 1'b0, 20, 1'b1);
      checks++;
      if (obs[0] !== K1 || obs[15] !== K16) begin
         errors++; $display("FAIL glitch_ends got %h %h want %h %h", obs[0], obs[15], K1, K16);
      end
   endtask

   task automatic test_reset_mid();
      int cyc;
      @(negedge clk);
      key_in = TKEY; decrypt = 1'b0; key_valid = 1'b1;
      @(negedge clk);
      key_valid = 1'b0; subkey_ready = 1'b1;
      cyc = 0;
      while (round_cnt != 4'd7 && cyc < 40) begin
         @(negedge clk); cyc++;
      end
      checks++;
      if (round_cnt !== 4'd7) begin
         errors++; $display("FAIL mid_reach got %0d want 7", round_cnt);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (subkey_valid !== 1'b0 || key_ready !== 1'b1 || round_cnt !== 4'd0 ||
          done !== 1'b0 || subkey !== 48'h0) begin
         errors++;
         $display("FAIL mid_reset valid %b ready %b cnt %0d done %b subkey %h want 0 1 0 0 0",
                  subkey_valid, key_ready, round_cnt, done, subkey);
      end
      subkey_ready = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (done !== 1'b0 || key_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset done %b ready %b want 0 1", done, key_ready);
         end
      end
      run_sched(TKEY, 1'b0, 0, 1'b0);
      checks++;
      if (obs[0] !== K1 || obs[15] !== K16) begin
         errors++; $display("FAIL reload_ends got %h %h want %h %h", obs[0], obs[15], K1, K16);
      end
   endtask

   task automatic test_weak_parity();
      logic [47:0] ref_keys[16];
      logic [63:0] k, mask;
      run_sched(64'h0, 1'b0, 10, 1'b0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (obs[i] !== 48'h0) begin errors++; $display("FAIL weak0 idx %0d got %h want 0", i, obs[i]); end
      end
      run_sched(64'hFFFFFFFFFFFFFFFF, 1'b1, 10, 1'b0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (obs[i] !== 48'hFFFFFFFFFFFF) begin
            errors++; $display("FAIL weak1 idx %0d got %h want ffffffffffff", i, obs[i]);
         end
      end
      k = {$urandom, $urandom};
      model(k);
      ref_keys = exp_enc;
      mask = {$urandom, $urandom} & 64'h0101010101010101;
      mask[0] = 1'b1;
      run_sched(k ^ mask, 1'b0, 25, 1'b0);
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (obs[i] !== ref_keys[i]) begin
            errors++; $display("FAIL parity idx %0d got %h want %h", i, obs[i], ref_keys[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      for (int n = 0; n < 4; n++) begin
         run_sched({$urandom, $urandom}, 1'($urandom_range(1)), 30, 1'($urandom_range(1)));
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_encrypt();
      test_decrypt();
      test_stall();
      test_key_glitch();
      test_reset_mid();
      test_weak_parity();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
